// File: rtl/led_panel_capture.sv
// led_panel_capture: panel-side receiver for the LED bit-plane shift/latch protocol.
// Deserialises each latched row and merges it into an 8-bit framebuffer by read-modify-write.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   panel_data/clk    serial bit and its shift clock (sampled on the rising edge)
//   panel_latch/addr  end-of-plane pulse and the scan row it belongs to
//   panel_enable_n    output enable; synchronised but not otherwise used
//   fb_rd_addr/data   framebuffer read port (data registered, 1-cycle latency)
//   fb_wr_en/addr/data framebuffer write port
//   busy              row sweep in progress
//   frame_strobe      1-cycle pulse on the plane-7 latch of row 0
//   err_overrun       sticky: latch while a sweep was still running
//   err_length        sticky: bit count at latch differed from DISPLAY_WIDTH
//   err_clear         synchronous clear of both sticky errors
module led_panel_capture #(
    parameter int DISP_ADDR_WIDTH = 4,
    parameter int DISPLAY_WIDTH   = 384,
    parameter int FB_ADDR_WIDTH   = 13,
    parameter int COL_WIDTH       = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       panel_data,
    input  logic                       panel_clk,
    input  logic                       panel_latch,
    input  logic                       panel_enable_n,
    input  logic [DISP_ADDR_WIDTH-1:0] panel_addr,
    output logic [FB_ADDR_WIDTH-1:0]   fb_rd_addr,
    input  logic [7:0]                 fb_rd_data,
    output logic                       fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0]   fb_wr_addr,
    output logic [7:0]                 fb_wr_data,
    output logic                       busy,
    output logic                       frame_strobe,
    output logic                       err_overrun,
    output logic                       err_length,
    input  logic                       err_clear
);
    localparam int SW = DISP_ADDR_WIDTH + 4;
    localparam logic [COL_WIDTH-1:0] FULL = COL_WIDTH'(DISPLAY_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    // All pins share one synchroniser so they stay cycle-aligned.
    logic [SW-1:0] meta_q, sync_q;

    logic                       s_data, s_clk, s_latch, s_en_n;
    logic [DISP_ADDR_WIDTH-1:0] s_addr;
    logic                       unused_en_n;

    assign {s_data, s_clk, s_latch, s_en_n, s_addr} = sync_q;
    assign unused_en_n = s_en_n;

    state_t                     state_q, state_d;
    logic                       prev_clk_q, prev_clk_d;
    logic                       prev_lat_q, prev_lat_d;
    logic [COL_WIDTH-1:0]       col_q, col_d;
    logic                       ovf_q, ovf_d;
    logic [DISPLAY_WIDTH-1:0]   rowbuf_q, rowbuf_d;
    logic [DISPLAY_WIDTH-1:0]   sweep_q, sweep_d;
    logic [2:0]                 plane_q, plane_d;
    logic [DISP_ADDR_WIDTH-1:0] last_q, last_d;
    logic [COL_WIDTH-1:0]       ncols_q, ncols_d;
    logic [FB_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [COL_WIDTH-1:0]       rdcol_q, rdcol_d;
    logic                       s1_vld_q, s1_vld_d;
    logic [FB_ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
    logic                       s1_bit_q, s1_bit_d;
    logic                       wr_en_q, wr_en_d;
    logic [FB_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic                       strobe_q, strobe_d;
    logic                       err_ovr_q, err_ovr_d;
    logic                       err_len_q, err_len_d;

    logic                       rise, lat_edge, sweeping;
    logic                       rd_valid;
    logic [FB_ADDR_WIDTH-1:0]   rd_addr, base_calc;
    logic [2:0]                 plane_nx;
    logic [7:0]                 mask, merged;

    assign rise      = s_clk & ~prev_clk_q;
    assign lat_edge  = s_latch & ~prev_lat_q;
    assign sweeping  = (state_q != S_IDLE);
    assign rd_valid  = (state_q == S_READ) && (rdcol_q < ncols_q);
    assign rd_addr   = base_q + FB_ADDR_WIDTH'(rdcol_q);
    assign base_calc = FB_ADDR_WIDTH'(s_addr) * FB_ADDR_WIDTH'(DISPLAY_WIDTH);
    assign plane_nx  = (s_addr != last_q) ? 3'd0 : plane_q + 3'd1;

    // Plane 0 rewrites the whole pixel so stale upper planes are cleared.
    assign mask   = 8'b1 << plane_q;
    assign merged = (plane_q == 3'd0) ? {7'b0, s1_bit_q}
                  : (fb_rd_data & ~mask) | (s1_bit_q ? mask : 8'h00);

    always_comb begin
        state_d    = state_q;
        prev_clk_d = s_clk;
        prev_lat_d = s_latch;
        col_d      = col_q;
        ovf_d      = ovf_q;
        rowbuf_d   = rowbuf_q;
        sweep_d    = sweep_q;
        plane_d    = plane_q;
        last_d     = last_q;
        ncols_d    = ncols_q;
        base_d     = base_q;
        rdcol_d    = rdcol_q;
        strobe_d   = 1'b0;
        err_ovr_d  = err_clear ? 1'b0 : err_ovr_q;
        err_len_d  = err_clear ? 1'b0 : err_len_q;

        s1_vld_d   = rd_valid;
        s1_addr_d  = rd_valid ? rd_addr : '0;
        s1_bit_d   = rd_valid ? sweep_q[rdcol_q] : 1'b0;
        wr_en_d    = s1_vld_q;
        wr_addr_d  = s1_vld_q ? s1_addr_q : '0;
        wr_data_d  = s1_vld_q ? merged : 8'h00;

        unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_READ: begin
                if (rd_valid)
                    rdcol_d = rdcol_q + COL_WIDTH'(1);
                if (!rd_valid || (rdcol_q + COL_WIDTH'(1) == ncols_q))
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A rise coinciding with the latch edge is column 0 of the next plane.
        if (lat_edge) begin
            col_d = '0;
            ovf_d = 1'b0;
            if (rise) begin
                rowbuf_d[0] = s_data;
                col_d       = COL_WIDTH'(1);
            end
        end else if (rise) begin
            if (col_q < FULL) begin
                rowbuf_d[col_q] = s_data;
                col_d           = col_q + COL_WIDTH'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (lat_edge) begin
            if (col_q != FULL || ovf_q)
                err_len_d = 1'b1;
            if (sweeping) begin
                err_ovr_d = 1'b1;
            end else begin
                sweep_d  = rowbuf_q;
                ncols_d  = col_q;
                base_d   = base_calc;
                plane_d  = plane_nx;
                last_d   = s_addr;
                rdcol_d  = '0;
                strobe_d = (s_addr == '0) && (plane_nx == 3'd7);
                state_d  = S_READ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            state_q    <= S_IDLE;
            prev_clk_q <= 1'b0;
            prev_lat_q <= 1'b0;
            col_q      <= '0;
            ovf_q      <= 1'b0;
            rowbuf_q   <= '0;
            sweep_q    <= '0;
            plane_q    <= 3'd0;
            last_q     <= '1;
            ncols_q    <= '0;
            base_q     <= '0;
            rdcol_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_bit_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            strobe_q   <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            meta_q     <= {panel_data, panel_clk, panel_latch,
                           panel_enable_n, panel_addr};
            sync_q     <= meta_q;
            state_q    <= state_d;
            prev_clk_q <= prev_clk_d;
            prev_lat_q <= prev_lat_d;
            col_q      <= col_d;
            ovf_q      <= ovf_d;
            rowbuf_q   <= rowbuf_d;
            sweep_q    <= sweep_d;
            plane_q    <= plane_d;
            last_q     <= last_d;
            ncols_q    <= ncols_d;
            base_q     <= base_d;
            rdcol_q    <= rdcol_d;
            s1_vld_q   <= s1_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_bit_q   <= s1_bit_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            strobe_q   <= strobe_d;
            err_ovr_q  <= err_ovr_d;
            err_len_q  <= err_len_d;
        end
    end

    assign fb_rd_addr   = rd_valid ? rd_addr : '0;
    assign fb_wr_en     = wr_en_q;
    assign fb_wr_addr   = wr_addr_q;
    assign fb_wr_data   = wr_data_q;
    assign busy         = sweeping;
    assign frame_strobe = strobe_q;
    assign err_overrun  = err_ovr_q;
    assign err_length   = err_len_q;

endmodule

// File: tb/tb_led_panel_capture.sv
// tb_led_panel_capture: randomized scoreboard bench for led_panel_capture.
// Narrow panel geometry keeps a full 16x8 frame short.
module tb_led_panel_capture;
    localparam int AW  = 4;
    localparam int W   = 64;
    localparam int FAW = 10;
    localparam int CW  = 7;
    localparam int FBN = 16 * W;

    typedef logic [FAW+7:0] exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pdata = 1'b0, pclk = 1'b0, platch = 1'b0, pen_n = 1'b1;
    logic [AW-1:0]  paddr = '0;
    logic [FAW-1:0] fb_rd_addr, fb_wr_addr;
    logic [7:0]     fb_rd_data = 8'h00, fb_wr_data;
    logic           fb_wr_en, busy, frame_strobe, err_overrun, err_length;
    logic           err_clear = 1'b0;

    led_panel_capture #(
        .DISP_ADDR_WIDTH(AW), .DISPLAY_WIDTH(W),
        .FB_ADDR_WIDTH(FAW), .COL_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .panel_data(pdata), .panel_clk(pclk),
        .panel_latch(platch), .panel_enable_n(pen_n),
        .panel_addr(paddr),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data), .busy(busy),
        .frame_strobe(frame_strobe),
        .err_overrun(err_overrun), .err_length(err_length),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int wr_seen = 0, strobe_seen = 0;
    int first_wr_cyc = -1, last_strobe_cyc = -1, latch_cyc = 0;

    // Framebuffer emulation; presets go through the same process.
    logic [7:0]     mem [FBN];
    logic           ram_clear = 1'b0, pre_en = 1'b0;
    logic [FAW-1:0] pre_a = '0;
    logic [7:0]     pre_v = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fb_rd_data <= mem[fb_rd_addr];
        if (ram_clear)
            for (int i = 0; i < FBN; i++) mem[i] <= 8'h00;
        else if (pre_en)
            mem[pre_a] <= pre_v;
        else if (fb_wr_en)
            mem[fb_wr_addr] <= fb_wr_data;
    end

    // Reference model
    logic [7:0]    model [FBN];
    exp_t          exp_q [$];
    logic [AW-1:0] m_last = '1;
    int            m_plane = 0;
    bit            exp_len = 0, exp_ovr = 0;
    int            exp_strobes = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_strobe) begin
                strobe_seen++;
                last_strobe_cyc = cyc;
            end
            if (fb_wr_en) begin
                exp_t e;
                wr_seen++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h expected none",
                             {fb_wr_addr, fb_wr_data});
                end else begin
                    e = exp_q.pop_front();
                    check("write", 64'({fb_wr_addr, fb_wr_data}), 64'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b, input bit fast);
        pdata = b;
        pclk  = 1'b0;
        repeat (fast ? 1 : $urandom_range(1, 2)) tick();
        pclk  = 1'b1;
        repeat (fast ? 1 : $urandom_range(1, 2)) tick();
    endtask

    task automatic model_latch(input logic [127:0] bits, input int n,
                               input logic [AW-1:0] addr, input bit drop);
        int nc;
        if (n != W) exp_len = 1;
        if (drop) begin
            exp_ovr = 1;
            return;
        end
        m_plane = (addr != m_last) ? 0 : (m_plane + 1) % 8;
        m_last  = addr;
        if (addr == 0 && m_plane == 7) exp_strobes++;
        nc = (n > W) ? W : n;
        for (int c = 0; c < nc; c++) begin
            int a;
            a = int'(addr) * W + c;
            if (m_plane == 0) model[a] = {7'b0, bits[c]};
            else model[a][m_plane] = bits[c];
            exp_q.push_back({FAW'(a), model[a]});
        end
    endtask

    task automatic send_row(input logic [127:0] bits, input int n,
                            input logic [AW-1:0] addr, input bit drop,
                            input bit fast);
        for (int i = 0; i < n; i++) shift_bit(bits[i], fast);
        pclk   = 1'b0;
        paddr  = addr;
        platch = 1'b1;
        latch_cyc = cyc;
        model_latch(bits, n, addr, drop);
        tick();
        platch = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        repeat (5) tick();
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) check("idle_timeout", 64'(busy), 64'(0));
        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic preset(input int a, input logic [7:0] v);
        pre_en = 1'b1;
        pre_a  = FAW'(a);
        pre_v  = v;
        tick();
        pre_en = 1'b0;
        model[a] = v;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_len = 0;
        exp_ovr = 0;
        tick();
        check("err_length_cleared", 64'(err_length), 64'(0));
        check("err_overrun_cleared", 64'(err_overrun), 64'(0));
    endtask

    task automatic cmp_row(input string name, input int r);
        for (int c = 0; c < W; c++)
            check(name, 64'(mem[r * W + c]), 64'(model[r * W + c]));
    endtask

    function automatic logic [127:0] rnd_bits();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]   img [16][W];
    logic [127:0] v;
    logic [7:0]   pix;
    int           s0, w0, k, r0p7;

    initial begin
        for (int i = 0; i < FBN; i++) model[i] = 8'h00;
        ram_clear = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              64'({fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data,
                   busy, frame_strobe, err_overrun, err_length}), 64'(0));
        ram_clear = 1'b0;
        reset = 1'b0;
        repeat (3) tick();

        // Row 3, column 5 = 0xA5 built from 8 planes
        pix = 8'hA5;
        for (int p = 0; p < 8; p++) begin
            v = '0;
            v[5] = pix[p];
            first_wr_cyc = -1;
            send_row(v, W, 4'd3, 0, p != 0);
            if (p == 0) begin
                k = 0;
                while (first_wr_cyc < 0 && k < 50) begin
                    tick();
                    k++;
                end
                check("latch_to_write_latency",
                      64'(first_wr_cyc - latch_cyc), 64'(5));
            end
            wait_idle();
        end
        check("t1_pixel_a5", 64'(mem[3 * W + 5]), 64'(8'hA5));
        check("t1_pixel_00", 64'(mem[3 * W + 4]), 64'(8'h00));
        check("t1_err_length", 64'(err_length), 64'(0));
        check("t1_err_overrun", 64'(err_overrun), 64'(0));

        // Plane 0 clears a preset pixel; plane 3 clears only its bit
        preset(10 * W + 2, 8'hFF);
        send_row('0, W, 4'd10, 0, 0);
        wait_idle();
        check("t5_plane0_clear", 64'(mem[10 * W + 2]), 64'(8'h00));
        for (int p = 0; p < 3; p++) begin
            send_row('1, W, 4'd11, 0, 0);
            wait_idle();
        end
        preset(11 * W + 2, 8'hFF);
        send_row('0, W, 4'd11, 0, 0);
        wait_idle();
        check("t5_plane3_clear", 64'(mem[11 * W + 2]), 64'(8'hF7));
        cmp_row("t5_row11", 11);

        // Short and long rows
        preset(7 * W + 40, 8'h5A);
        send_row(rnd_bits(), 40, 4'd7, 0, 0);
        wait_idle();
        check("t3_short_untouched", 64'(mem[7 * W + 40]), 64'(8'h5A));
        check("t3_short_err_length", 64'(err_length), 64'(exp_len));
        check("t3_short_err_overrun", 64'(err_overrun), 64'(0));
        cmp_row("t3_short_row", 7);
        clear_errs();
        preset(9 * W, 8'h3C);
        send_row(rnd_bits(), 70, 4'd8, 0, 0);
        wait_idle();
        check("t3_long_err_length", 64'(err_length), 64'(1));
        check("t3_long_next_row", 64'(mem[9 * W]), 64'(8'h3C));
        cmp_row("t3_long_row", 8);
        clear_errs();

        // Latch during a sweep is dropped
        send_row(rnd_bits(), W, 4'd12, 0, 1);
        send_row(rnd_bits(), 4, 4'd13, 1, 1);
        wait_idle();
        check("t4_err_overrun", 64'(err_overrun), 64'(exp_ovr));
        check("t4_err_length", 64'(err_length), 64'(1));
        cmp_row("t4_row12", 12);
        cmp_row("t4_row13", 13);
        clear_errs();

        // Asynchronous reset in the middle of a sweep
        w0 = wr_seen;
        send_row(rnd_bits(), W, 4'd5, 0, 1);
        k = 0;
        while (wr_seen < w0 + 32 && k < 500) begin
            tick();
            k++;
        end
        check("t6_reached_mid_sweep", 64'(wr_seen >= w0 + 32), 64'(1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_outputs",
              64'({fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data,
                   busy, frame_strobe, err_overrun, err_length}), 64'(0));
        exp_q.delete();
        m_last = '1;
        m_plane = 0;
        exp_len = 0;
        exp_ovr = 0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        send_row(rnd_bits(), W, 4'd5, 0, 0);
        wait_idle();
        cmp_row("t6_row5_after_reset", 5);

        // Full random frame
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
        s0 = strobe_seen;
        r0p7 = -1;
        for (int r = 0; r < 16; r++)
            for (int p = 0; p < 8; p++) begin
                v = '0;
                for (int c = 0; c < W; c++) v[c] = img[r][c][p];
                send_row(v, W, AW'(r), 0, 0);
                if (r == 0 && p == 7) r0p7 = latch_cyc;
            end
        wait_idle();
        check("t2_strobe_count", 64'(strobe_seen - s0), 64'(1));
        check("t2_strobe_timing", 64'(last_strobe_cyc - r0p7), 64'(3));
        check("t2_err_length", 64'(err_length), 64'(0));
        check("t2_err_overrun", 64'(err_overrun), 64'(0));
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < W; c++)
                check("t2_image", 64'(mem[r * W + c]), 64'(img[r][c]));

        check("strobe_total", 64'(strobe_seen), 64'(exp_strobes));
        for (int i = 0; i < FBN; i++)
            check("final_model", 64'(mem[i]), 64'(model[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
